// File: rtl/uart_alu_sequencer.sv
// Pops A, B, Op from the UART RX FIFO, drives the ALU, and pushes the result to the UART TX FIFO.
// Latency: 2 cycles from the last byte pop to wr_uart (EXEC, SEND). Backpressure: waits on rx_empty and tx_full.
// CMD_TIMEOUT_EN adds an abort of a partial command after TIMEOUT_CYCLES idle cycles.
module uart_alu_sequencer #(
  parameter int SIZE           = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [SIZE-1:0] rx_data,
  output logic            rd_uart,
  output logic [SIZE-1:0] alu_a,
  output logic [SIZE-1:0] alu_b,
  output logic [5:0]      alu_op,
  input  logic [SIZE-1:0] alu_result,
  input  logic            tx_full,
  output logic [SIZE-1:0] tx_data,
  output logic            wr_uart,
  output logic            busy
);

  typedef enum logic [2:0] {
    S_GET_A,
    S_GET_B,
    S_GET_OP,
    S_EXEC,
    S_SEND
  } state_t;

  state_t          r_state;
  logic [SIZE-1:0] r_alu_a;
  logic [SIZE-1:0] r_alu_b;
  logic [5:0]      r_alu_op;
  logic [SIZE-1:0] r_tx_data;
  logic            w_get;
  logic            w_abort;

  assign w_get   = (r_state == S_GET_A) || (r_state == S_GET_B) || (r_state == S_GET_OP);
  assign rd_uart = !reset && w_get && !rx_empty;
  assign wr_uart = !reset && (r_state == S_SEND) && !tx_full;
  assign busy    = (r_state != S_GET_A);
  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_op  = r_alu_op;
  assign tx_data = r_tx_data;

`ifdef CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_tmo_cnt;
  logic          w_mid_cmd;

  assign w_mid_cmd = (r_state == S_GET_B) || (r_state == S_GET_OP);
  // An arriving byte wins over an expiring counter.
  assign w_abort   = w_mid_cmd && rx_empty && (r_tmo_cnt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
    end else if (w_mid_cmd && rx_empty && !w_abort) begin
      r_tmo_cnt <= r_tmo_cnt + CW'(1);
    end else begin
      r_tmo_cnt <= '0;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_GET_A;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_tx_data <= '0;
    end else begin
      case (r_state)
        S_GET_A: begin
          if (!rx_empty) begin
            r_alu_a <= rx_data;
            r_state <= S_GET_B;
          end
        end
        S_GET_B: begin
          if (!rx_empty) begin
            r_alu_b <= rx_data;
            r_state <= S_GET_OP;
          end else if (w_abort) begin
            r_state <= S_GET_A;
          end
        end
        S_GET_OP: begin
          if (!rx_empty) begin
            r_alu_op <= rx_data[5:0];
            r_state  <= S_EXEC;
          end else if (w_abort) begin
            r_state <= S_GET_A;
          end
        end
        S_EXEC: begin
          r_tx_data <= alu_result;
          r_state   <= S_SEND;
        end
        S_SEND: begin
          if (!tx_full) begin
            r_state <= S_GET_A;
          end
        end
        default: r_state <= S_GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Bench for uart_alu_sequencer: FIFO-like RX/TX stubs, a command-level model, and directed commands.
module tb_uart_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       tx_full = 1'b0;
  logic       rd_uart, wr_uart, busy;
  logic [7:0] alu_a, alu_b, tx_data, alu_result;
  logic [5:0] alu_op;

  uart_alu_sequencer #(.SIZE(8), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_empty   (rx_empty),
    .rx_data    (rx_data),
    .rd_uart    (rd_uart),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .tx_full    (tx_full),
    .tx_data    (tx_data),
    .wr_uart    (wr_uart),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);

  logic [7:0] rx_q[$];
  logic       pop_pend = 1'b0;
  logic       tx_hold = 1'b0;
  bit         tmo_mode = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         wr_count = 0;
  int         exp_wr = 0;

  // Command-level model: bytes popped so far, results owed to TX, operands of the last command.
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_a, exp_b;
  logic [5:0] exp_op;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic refresh();
    rx_empty = (rx_q.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rx_q[0];
    tx_full  = tx_hold;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (pop_pend) begin
        void'(rx_q.pop_front());
        pop_pend = 1'b0;
      end
      refresh();
    end
  end

  always @(negedge clk) begin
    logic [7:0] b2;
    if (reset) begin
      got.delete();
      exp_q.delete();
    end else begin
      if (!tmo_mode) chk("busy", busy, (got.size() > 0 || exp_q.size() > 0));
      chk("rd_wr_exclusive", rd_uart & wr_uart, 0);
      if (tx_full) chk("wr_when_full", wr_uart, 0);
      if (rd_uart) begin
        chk("rd_with_data", rx_empty, 0);
        chk("rd_while_result_owed", exp_q.size(), 0);
        got.push_back(rx_data);
        pop_pend = 1'b1;
        if (got.size() == 3) begin
          b2     = got[2];
          exp_a  = got[0];
          exp_b  = got[1];
          exp_op = b2[5:0];
          exp_q.push_back(alu_f(exp_a, exp_b, exp_op));
          got.delete();
        end
      end
      if (wr_uart) begin
        wr_count++;
        chk("result_owed_on_wr", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("tx_data", tx_data, exp_q.pop_front());
          chk("alu_a_on_wr", alu_a, exp_a);
          chk("alu_b_on_wr", alu_b, exp_b);
          chk("alu_op_on_wr", alu_op, exp_op);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic push(input logic [7:0] b);
    rx_q.push_back(b);
    refresh();
  endtask

  task automatic drain();
    int n = 0;
    while ((rx_q.size() != 0 || pop_pend) && n < 200) begin
      tick();
      n++;
    end
    chk("rx_drained", rx_q.size(), 0);
  endtask

  task automatic wait_wr(input string name, input logic [7:0] expv);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (wr_uart) begin
        seen = 1'b1;
        chk(name, tx_data, expv);
      end
    end
    chk({name, "_wr_seen"}, seen, 1);
    exp_wr++;
    tick();
  endtask

  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input int gap, input string name, input logic [7:0] expv);
    push(a);
    if (gap > 0) begin drain(); repeat (gap) tick(); end
    push(b);
    if (gap > 0) begin drain(); repeat (gap) tick(); end
    push(op);
    wait_wr(name, expv);
  endtask

  task automatic chk_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_rd"}, rd_uart, 0);
    chk({tag, "_wr"}, wr_uart, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_op"}, alu_op, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
  endtask

  initial begin
    int base;
    refresh();
    repeat (2) @(posedge clk);
    chk_reset_vals("reset");
    tick();
    reset = 1'b0;
    tick();

    run_cmd(8'h05, 8'h03, 8'h20, 0, "add_05_03", 8'h08);
    chk("t1_alu_a", alu_a, 8'h05);
    chk("t1_alu_b", alu_b, 8'h03);
    chk("t1_alu_op", alu_op, 6'h20);

    run_cmd(8'h03, 8'h05, 8'h22, 0, "sub_wrap", 8'hFE);
    run_cmd(8'hF0, 8'h0F, 8'h27, 0, "nor_zero", 8'h00);
    run_cmd(8'h09, 8'h04, 8'hE2, 0, "op_high_bits_ignored", 8'h05);
    chk("op_masked", alu_op, 6'h22);

    run_cmd(8'h05, 8'h03, 8'h20, 5, "gapped_add", 8'h08);

    // TX stall: four full cycles in SEND, then a single push once it drains.
    base = wr_count;
    tx_hold = 1'b1;
    refresh();
    push(8'h55); push(8'hAA); push(8'h26);
    drain();
    @(negedge clk);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_no_wr", wr_uart, 0);
      chk("stall_tx_stable", tx_data, 8'hFF);
      tick();
    end
    tx_hold = 1'b0;
    refresh();
    @(negedge clk);
    chk("stall_release_wr", wr_uart, 1);
    chk("stall_release_data", tx_data, 8'hFF);
    exp_wr++;
    tick();
    @(negedge clk);
    chk("stall_single_wr", wr_count - base, 1);
    tick();

    // Two commands queued at once; the second A byte may pop right after the first push.
    base = wr_count;
    push(8'h10); push(8'h20); push(8'h25);
    push(8'h81); push(8'h7F); push(8'h20);
    wait_wr("b2b_or", 8'h30);
    wait_wr("b2b_add_wrap", 8'h00);
    chk("b2b_wr_count", wr_count - base, 2);

    // Reset after A and B accepted: partial command discarded.
    base = wr_count;
    push(8'h11); push(8'h22);
    drain();
    tick();
    reset = 1'b1;
    chk_reset_vals("mid_cmd_reset");
    tick();
    reset = 1'b0;
    tick();
    run_cmd(8'h01, 8'h01, 8'h20, 0, "after_reset_add", 8'h02);
    chk("after_reset_wr_count", wr_count - base, 1);

    // Reset while a result is held in SEND: that result is never pushed.
    base = wr_count;
    tx_hold = 1'b1;
    refresh();
    push(8'h03); push(8'h04); push(8'h20);
    drain();
    repeat (3) tick();
    reset = 1'b1;
    chk_reset_vals("send_reset");
    tick();
    reset = 1'b0;
    tx_hold = 1'b0;
    refresh();
    repeat (5) tick();
    chk("send_dropped", wr_count - base, 0);

`ifdef CMD_TIMEOUT_EN
    base = wr_count;
    tmo_mode = 1'b1;
    push(8'h07);
    drain();
    repeat (20) tick();
    @(negedge clk);
    chk("timeout_idle", busy, 0);
    got.delete();
    tmo_mode = 1'b0;
    tick();
    run_cmd(8'h02, 8'h02, 8'h20, 0, "after_timeout_add", 8'h04);
    chk("timeout_wr_count", wr_count - base, 1);
`endif

    repeat (3) tick();
    chk("total_wr", wr_count, exp_wr);
    chk("no_leftover_results", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
